// File: rtl/out_display_unit.sv
// Output-port slot file with an 8-digit multiplexed hex 7-segment display.
// Captures processor OUT strobes and scans two selected slots onto the digits.
module out_display_unit #(
    parameter int SCAN_DIV = 1000,
    parameter int BLANK    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        outdisplay,
    input  logic [2:0]  outsel,
    input  logic [15:0] outval1,
    input  logic [15:0] outval2,
    input  logic [1:0]  page,
    input  logic [2:0]  rd_sel,
    output logic [15:0] rd_data,
    output logic [15:0] aux_q,
    output logic [7:0]  valid,
    output logic        updated,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    logic [15:0] slot_q [8];
    logic [7:0]  valid_q;
    logic [15:0] aux_q_r;
    logic        updated_q;
    logic [15:0] pre_q, pre_d;
    logic [2:0]  digit_q, digit_d;
    logic [7:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;

    logic        pre_wrap;
    logic [2:0]  dsel;
    logic [15:0] dword;
    logic [3:0]  nib;
    logic        dp_on;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'b1000000;
            4'h1: r = 7'b1111001;
            4'h2: r = 7'b0100100;
            4'h3: r = 7'b0110000;
            4'h4: r = 7'b0011001;
            4'h5: r = 7'b0010010;
            4'h6: r = 7'b0000010;
            4'h7: r = 7'b1111000;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0010000;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b0000011;
            4'hC: r = 7'b1000110;
            4'hD: r = 7'b0100001;
            4'hE: r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    // Slot file, valid map and strobe capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) slot_q[i] <= '0;
            valid_q   <= '0;
            aux_q_r   <= '0;
            updated_q <= 1'b0;
        end else begin
            updated_q <= outdisplay;
            if (outdisplay) begin
                slot_q[outsel]  <= outval1;
                valid_q[outsel] <= 1'b1;
                aux_q_r         <= outval2;
            end
        end
    end

    assign pre_wrap = (pre_q == 16'(SCAN_DIV - 1));

    always_comb begin
        pre_d   = pre_wrap ? '0 : pre_q + 16'd1;
        digit_d = pre_wrap ? digit_q + 3'd1 : digit_q;
    end

    // Digits 0-3 come from slot 2*page, digits 4-7 from slot 2*page+1
    assign dsel  = {page, digit_q[2]};
    assign dword = slot_q[dsel];
    assign nib   = dword[{digit_q[1:0], 2'b00} +: 4];
    assign dp_on = (digit_q[1:0] == 2'd0) && valid_q[dsel];

    always_comb begin
        an_d  = (pre_q < 16'(BLANK)) ? 8'hFF : ~(8'd1 << digit_q);
        seg_d = {~dp_on, hex7(nib)};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            digit_q <= '0;
            an_q    <= 8'hFF;
            seg_q   <= 8'hFF;
        end else begin
            pre_q   <= pre_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign rd_data = slot_q[rd_sel];
    assign aux_q   = aux_q_r;
    assign valid   = valid_q;
    assign updated = updated_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule

// File: tb/tb_out_display_unit.sv
// Directed bench for out_display_unit with a short scan period.
module tb_out_display_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        outdisplay = 1'b0;
    logic [2:0]  outsel = '0;
    logic [15:0] outval1 = '0;
    logic [15:0] outval2 = '0;
    logic [1:0]  page = '0;
    logic [2:0]  rd_sel = '0;
    logic [15:0] rd_data;
    logic [15:0] aux_q;
    logic [7:0]  valid;
    logic        updated;
    logic [7:0]  an;
    logic [7:0]  seg;

    int n_chk = 0;
    int n_err = 0;

    out_display_unit #(.SCAN_DIV(8), .BLANK(2)) dut (
        .clock(clock), .reset(reset), .outdisplay(outdisplay),
        .outsel(outsel), .outval1(outval1), .outval2(outval2),
        .page(page), .rd_sel(rd_sel), .rd_data(rd_data),
        .aux_q(aux_q), .valid(valid), .updated(updated),
        .an(an), .seg(seg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h40; 4'h1: r = 7'h79; 4'h2: r = 7'h24;
            4'h3: r = 7'h30; 4'h4: r = 7'h19; 4'h5: r = 7'h12;
            4'h6: r = 7'h02; 4'h7: r = 7'h78; 4'h8: r = 7'h00;
            4'h9: r = 7'h10; 4'hA: r = 7'h08; 4'hB: r = 7'h03;
            4'hC: r = 7'h46; 4'hD: r = 7'h21; 4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    task automatic strobe(input logic [2:0] s, input logic [15:0] v1,
                          input logic [15:0] v2);
        outdisplay = 1'b1;
        outsel     = s;
        outval1    = v1;
        outval2    = v2;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " an"}, an, 8'hFF);
        chk({tag, " seg"}, seg, 8'hFF);
        chk({tag, " valid"}, valid, 8'h00);
        chk({tag, " upd"}, updated, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd_sel = 3'(i);
            #1;
            chk($sformatf("%s rd%0d", tag, i), rd_data, 16'h0000);
        end
    endtask

    logic [15:0] m_slot [8];
    logic [7:0]  m_val;
    logic [1:0]  pg;

    initial begin
        repeat (2) @(negedge clock);
        chk_reset_state("rst0");
        reset = 1'b0;

        // single capture, with readback of the slot being written
        @(negedge clock);
        strobe(3'd3, 16'hBEEF, 16'h1234);
        rd_sel = 3'd3;
        #1 chk("rd_old", rd_data, 16'h0000);
        @(negedge clock);
        outdisplay = 1'b0;
        chk("rd3", rd_data, 16'hBEEF);
        chk("valid08", valid, 8'h08);
        chk("aux", aux_q, 16'h1234);
        chk("upd1", updated, 1'b1);
        @(negedge clock);
        chk("upd0", updated, 1'b0);

        // back-to-back strobes
        strobe(3'd1, 16'h1111, 16'h0001);
        @(negedge clock);
        strobe(3'd2, 16'h2222, 16'h0002);
        chk("b2b upd a", updated, 1'b1);
        @(negedge clock);
        outdisplay = 1'b0;
        chk("b2b upd b", updated, 1'b1);
        rd_sel = 3'd1;
        #1 chk("b2b rd1", rd_data, 16'h1111);
        rd_sel = 3'd2;
        #1 chk("b2b rd2", rd_data, 16'h2222);
        chk("b2b aux", aux_q, 16'h0002);
        chk("valid0e", valid, 8'h0E);
        @(negedge clock);
        chk("b2b upd c", updated, 1'b0);

        // held strobe: last write wins
        strobe(3'd5, 16'h0001, 16'h0);
        @(negedge clock);
        outval1 = 16'h0002;
        @(negedge clock);
        outval1 = 16'h0003;
        @(negedge clock);
        outdisplay = 1'b0;
        rd_sel = 3'd5;
        #1 chk("held rd5", rd_data, 16'h0003);
        chk("valid2e", valid, 8'h2E);

        // scan decode from a fresh reset
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        page  = 2'd0;
        strobe(3'd0, 16'h0123, 16'h0);
        for (int i = 0; i < 8; i++) m_slot[i] = '0;
        m_slot[0] = 16'h0123;
        m_slot[1] = 16'h89AF;
        m_slot[7] = 16'hC0DE;
        m_val = 8'h83;
        pg = 2'd0;
        for (int e = 1; e <= 600; e++) begin
            int p, d;
            logic [15:0] w;
            logic [3:0]  n;
            logic        dp;
            logic [7:0]  exp_an;
            @(negedge clock);
            outdisplay = 1'b0;
            if (e == 11) strobe(3'd1, 16'h89AF, 16'h0);
            if (e == 19) strobe(3'd7, 16'hC0DE, 16'h0);
            p = (e - 1) % 8;
            d = ((e - 1) / 8) % 8;
            exp_an = (p < 2) ? 8'hFF : ~(8'd1 << d);
            if (e <= 3)
                chk($sformatf("first an e%0d", e), an,
                    (e == 3) ? 8'hFE : 8'hFF);
            chk($sformatf("an e%0d", e), an, exp_an);
            if (e >= 2) begin
                w  = (d < 4) ? m_slot[2*pg] : m_slot[2*pg+1];
                n  = 4'(w >> (4 * (d % 4)));
                dp = !((d == 0 && m_val[2*pg]) || (d == 4 && m_val[2*pg+1]));
                chk($sformatf("seg e%0d", e), seg, {dp, seg7(n)});
            end
            if (e == 548) begin
                page = 2'd3;
                pg   = 2'd3;
            end
        end
        chk("scan valid", valid, 8'h83);
        rd_sel = 3'd7;
        #1 chk("scan rd7", rd_data, 16'hC0DE);

        // reset asserted ahead of a strobe edge, mid-frame
        @(negedge clock);
        strobe(3'd6, 16'hABCD, 16'h5555);
        #2 reset = 1'b1;
        #1 chk("async an", an, 8'hFF);
        chk("async seg", seg, 8'hFF);
        chk("async valid", valid, 8'h00);
        @(negedge clock);
        chk_reset_state("rstw");
        chk("rstw aux", aux_q, 16'h0000);
        outdisplay = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("post upd", updated, 1'b0);
        chk("post valid", valid, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
